host_prog_loader: RTL and testbench
===================================

HOST_PROG_LOADER -- requirements
Module: host_prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16: program buffer entries, power of two, at least 4.
REQ-002 SHALL have parameter WIDTH, default 32: program word width, equal to the pkg_mpu data width.
REQ-003 SHALL have port clock, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port I_Valid, input, 1: host word valid.
REQ-006 SHALL have port I_Data, input, WIDTH: host program word.
REQ-007 SHALL have port I_Last, input, 1: marks the final word of a program.
REQ-008 SHALL have port O_Ready, output, 1: loader accepts a host word.
REQ-009 SHALL have port O_Req_IF, output, 1: word-valid strobe to the engine I_Req_IF.
REQ-010 SHALL have port O_Data_IF, output, WIDTH: program word to the engine I_Data_IF.
REQ-011 SHALL have port I_Wait, input, 1: engine waiting for a thread program (engine O_Wait).
REQ-012 SHALL have port I_Stall, input, 1: engine back-pressure; holds the current word.
REQ-013 SHALL have port I_Clear, input, 1: abort, or clear an error.
REQ-014 SHALL have port O_Count, output, $clog2(DEPTH)+1: words currently buffered.
REQ-015 SHALL have port O_Done, output, 1: one-cycle pulse after the last word is sent.
REQ-016 SHALL have port O_Err, output, 1: program exceeded DEPTH.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, ARM, SEND and ERR.
REQ-018 SHALL perform a host transfer only on a cycle where I_Valid and O_Ready are both high.
REQ-019 SHALL drive O_Ready=1 only in IDLE or FILL, and only while O_Count<DEPTH.
REQ-020 SHALL write each accepted word at the write pointer; pointers wrap modulo DEPTH.
REQ-021 SHALL go IDLE->FILL on a transfer with I_Last=0, and IDLE->ARM on a transfer with I_Last=1.
REQ-022 SHALL go FILL->ARM on a transfer with I_Last=1.
REQ-023 SHALL go FILL->ERR on the transfer that fills the buffer (O_Count reaches DEPTH) with I_Last=0; a DEPTH-word program ending with I_Last=1 is legal.
REQ-024 SHALL go ARM->SEND in the cycle after I_Wait is sampled high; ARM with I_Wait=0 waits indefinitely.
REQ-025 SHALL drive O_Req_IF = (state==SEND) && !I_Stall, with O_Data_IF equal to the head word whenever in SEND.
REQ-026 SHALL pop one word on each cycle O_Req_IF=1, so that a program of N words with no stall takes N consecutive cycles.
REQ-027 SHALL continue SEND when I_Wait falls mid-program; a program in flight is committed.
REQ-028 SHALL go SEND->IDLE on the pop of the last word, and pulse O_Done=1 in the following cycle.
REQ-029 SHALL hold O_Err=1 in ERR, flush the buffer, and hold O_Ready=0 there.
REQ-030 SHALL on I_Clear=1 in any state go to IDLE next cycle, flush the buffer (O_Count=0) and drop O_Err; I_Clear has priority over every other transition.
REQ-031 SHALL drive O_Data_IF to 0 outside SEND.

Reset
REQ-032 SHALL on reset go to IDLE with pointers=0, O_Count=0, O_Req_IF=0, O_Done=0, O_Err=0 and O_Data_IF=0.
REQ-033 SHALL abort any state on reset mid-operation with no partial words emitted afterward; buffer contents need not be cleared.

Structure
REQ-034 SHALL place the state enum (ldr_state_t) and the DEPTH/WIDTH defaults in pkg_mpu.
REQ-035 SHALL implement storage as one sub-module, prog_fifo (synchronous FIFO with push, pop, count, full and empty), which the FSM controls.

Verification
REQ-036 SHALL cover: 4 words 0xA0..0xA3 with I_Last on the 4th, I_Wait=1 -> O_Req_IF high for 4 consecutive cycles carrying 0xA0..0xA3 in order, then O_Done pulse.
REQ-037 SHALL cover: 3-word load with I_Wait held 0 for 10 cycles -> ARM held, O_Req_IF=0, O_Count=3, O_Ready=0; raising I_Wait then starts SEND.
REQ-038 SHALL cover: I_Stall high 2 cycles during word 2 of 4 -> word 2 held, 6 total SEND cycles, no loss or duplication.
REQ-039 SHALL cover: 16 words with I_Last=0 at DEPTH=16 -> O_Err=1, O_Count=0; I_Clear -> IDLE with O_Ready=1.
REQ-040 SHALL cover: exactly 16 words with I_Last on the 16th -> no error, all 16 sent, pointer wrap correct on a second program.
REQ-041 SHALL cover: reset asserted mid-SEND after 2 of 5 words -> next cycle O_Req_IF=0, O_Count=0, state IDLE.

Source files
------------

// File: rtl/pkg_mpu.sv
// Shared definitions for the MPU host-side program loader.
// Holds the loader state encoding and the default buffer geometry.
package pkg_mpu;

    localparam int LDR_DEPTH = 16;
    localparam int LDR_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARM,
        SEND,
        ERR
    } ldr_state_t;

endpackage

// File: rtl/prog_fifo.sv
// Synchronous program-word FIFO with flush; the head word is presented combinationally.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module prog_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CNT_FULL);
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Flush shares the reset path so a flushed buffer always restarts at slot 0.
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_doPush} - {{AW{1'b0}}, w_doPop};
        end
    end

    always_ff @(posedge clock) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/host_prog_loader.sv
// Buffers a host-supplied program and replays it to the engine instruction port
// once the engine signals it is waiting; oversize programs latch an error until cleared.
module host_prog_loader
    import pkg_mpu::*;
#(
    parameter int DEPTH = LDR_DEPTH,
    parameter int WIDTH = LDR_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     I_Valid,
    input  logic [WIDTH-1:0]         I_Data,
    input  logic                     I_Last,
    output logic                     O_Ready,
    output logic                     O_Req_IF,
    output logic [WIDTH-1:0]         O_Data_IF,
    input  logic                     I_Wait,
    input  logic                     I_Stall,
    input  logic                     I_Clear,
    output logic [$clog2(DEPTH):0]   O_Count,
    output logic                     O_Done,
    output logic                     O_Err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    ldr_state_t      r_state;
    ldr_state_t      w_nextState;
    logic            r_done;
    logic            w_xfer;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic [WIDTH-1:0] w_head;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;

    prog_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (I_Data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign O_Ready   = ((r_state == IDLE) || (r_state == FILL)) && !w_full;
    assign w_xfer    = I_Valid && O_Ready;
    assign w_push    = w_xfer && !I_Clear;
    assign O_Req_IF  = (r_state == SEND) && !I_Stall && !w_empty;
    assign w_pop     = O_Req_IF;
    assign O_Data_IF = (r_state == SEND) ? w_head : '0;
    assign O_Count   = w_count;
    assign O_Done    = r_done;
    assign O_Err     = (r_state == ERR);
    // Flushing on the overflowing transfer itself means O_Count already reads 0 when O_Err rises.
    assign w_flush   = I_Clear || (r_state == ERR) || (w_nextState == ERR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= !I_Clear && (r_state == SEND) && w_pop && (w_count == CNT_ONE);
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (I_Clear) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_xfer) w_nextState = I_Last ? ARM : FILL;
                FILL: begin
                    if (w_xfer) begin
                        if (I_Last)                    w_nextState = ARM;
                        else if (w_count == CNT_LAST)  w_nextState = ERR;
                    end
                end
                ARM:  if (I_Wait) w_nextState = SEND;
                SEND: if (w_pop && (w_count == CNT_ONE)) w_nextState = IDLE;
                ERR:  w_nextState = ERR;
                default: w_nextState = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_prog_loader.sv
// Directed self-checking bench for host_prog_loader at DEPTH=16, WIDTH=32.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_host_prog_loader;
    import pkg_mpu::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Valid;
    logic [31:0] I_Data;
    logic        I_Last;
    logic        O_Ready;
    logic        O_Req_IF;
    logic [31:0] O_Data_IF;
    logic        I_Wait;
    logic        I_Stall;
    logic        I_Clear;
    logic [4:0]  O_Count;
    logic        O_Done;
    logic        O_Err;

    int checks   = 0;
    int failures = 0;

    host_prog_loader #(.DEPTH(16), .WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .I_Valid   (I_Valid),
        .I_Data    (I_Data),
        .I_Last    (I_Last),
        .O_Ready   (O_Ready),
        .O_Req_IF  (O_Req_IF),
        .O_Data_IF (O_Data_IF),
        .I_Wait    (I_Wait),
        .I_Stall   (I_Stall),
        .I_Clear   (I_Clear),
        .O_Count   (O_Count),
        .O_Done    (O_Done),
        .O_Err     (O_Err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One host handshake; the loader is expected to be ready in every call made here.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        I_Valid = 1'b1;
        I_Data  = data;
        I_Last  = last;
        tick();
        I_Valid = 1'b0;
        I_Last  = 1'b0;
        I_Data  = '0;
    endtask

    initial begin
        logic [31:0] words [$];
        logic        reqSeen;
        logic        doneSeen;
        int          sendCycles;
        int          stalls;

        reset = 1'b1; I_Valid = 0; I_Data = '0; I_Last = 0;
        I_Wait = 0; I_Stall = 0; I_Clear = 0;
        tick(); tick();
        reset = 1'b0;
        checkOutput("rst_count", 32'(O_Count), 0);
        checkOutput("rst_req",   32'(O_Req_IF), 0);
        checkOutput("rst_done",  32'(O_Done), 0);
        checkOutput("rst_err",   32'(O_Err), 0);
        checkOutput("rst_data",  O_Data_IF, 0);
        checkOutput("rst_ready", 32'(O_Ready), 1);

        // Four-word program with the engine already waiting.
        $display("[TB] basic four-word program");
        I_Wait = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(32'hA0 + 32'(i), i == 3);
        checkOutput("t1_arm_req",   32'(O_Req_IF), 0);
        checkOutput("t1_arm_count", 32'(O_Count), 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_req",  32'(O_Req_IF), 1);
            checkOutput("t1_data", O_Data_IF, 32'hA0 + 32'(i));
            tick();
        end
        checkOutput("t1_done",     32'(O_Done), 1);
        checkOutput("t1_req_end",  32'(O_Req_IF), 0);
        tick();
        checkOutput("t1_done_one", 32'(O_Done), 0);

        // ARM holds while the engine is not waiting; a late drop of I_Wait does not stop SEND.
        $display("[TB] arm hold");
        I_Wait = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(32'hB0 + 32'(i), i == 2);
        reqSeen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            reqSeen |= O_Req_IF;
            tick();
        end
        checkOutput("t2_hold_req",   32'(reqSeen), 0);
        checkOutput("t2_hold_count", 32'(O_Count), 3);
        checkOutput("t2_hold_ready", 32'(O_Ready), 0);
        I_Wait = 1'b1;
        tick();
        I_Wait = 1'b0;
        checkOutput("t2_req0",  32'(O_Req_IF), 1);
        checkOutput("t2_data0", O_Data_IF, 32'hB0);
        tick();
        checkOutput("t2_data1", O_Data_IF, 32'hB1);
        tick();
        checkOutput("t2_req2",  32'(O_Req_IF), 1);
        checkOutput("t2_data2", O_Data_IF, 32'hB2);
        tick();
        checkOutput("t2_done",  32'(O_Done), 1);

        // Two stall cycles on the second word of four.
        $display("[TB] stall during word 2");
        I_Wait = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(32'hC0 + 32'(i), i == 3);
        words.delete();
        sendCycles = 0; stalls = 0; doneSeen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (words.size() == 1 && stalls < 2) begin
                I_Stall = 1'b1;
                stalls++;
            end else begin
                I_Stall = 1'b0;
            end
            #1;
            if (O_Data_IF != 0) sendCycles++;
            if (O_Req_IF) words.push_back(O_Data_IF);
            if (O_Done) doneSeen = 1'b1;
            tick();
        end
        I_Stall = 1'b0;
        checkOutput("t3_send_cycles", 32'(sendCycles), 6);
        checkOutput("t3_word_count",  32'(words.size()), 4);
        for (int i = 0; i < 4; i++)
            checkOutput("t3_word", (i < words.size()) ? words[i] : 32'hDEAD, 32'hC0 + 32'(i));
        checkOutput("t3_done_seen", 32'(doneSeen), 1);

        // Sixteen words without I_Last overflow the buffer.
        $display("[TB] overflow");
        I_Wait = 1'b0;
        for (int i = 0; i < 15; i++) applyStimulus(32'hD0 + 32'(i), 1'b0);
        checkOutput("t4_count15", 32'(O_Count), 15);
        checkOutput("t4_err15",   32'(O_Err), 0);
        applyStimulus(32'hDF, 1'b0);
        checkOutput("t4_err",   32'(O_Err), 1);
        checkOutput("t4_count", 32'(O_Count), 0);
        checkOutput("t4_ready", 32'(O_Ready), 0);
        tick();
        checkOutput("t4_err_hold", 32'(O_Err), 1);
        I_Clear = 1'b1;
        tick();
        I_Clear = 1'b0;
        checkOutput("t4_clr_err",   32'(O_Err), 0);
        checkOutput("t4_clr_ready", 32'(O_Ready), 1);
        checkOutput("t4_clr_count", 32'(O_Count), 0);

        // Exactly DEPTH words ending in I_Last, then a short program after the pointers wrap.
        $display("[TB] full-depth program and wrap");
        for (int i = 0; i < 16; i++) applyStimulus(32'hE000_0000 + 32'(i), i == 15);
        checkOutput("t5_err",   32'(O_Err), 0);
        checkOutput("t5_count", 32'(O_Count), 16);
        checkOutput("t5_ready", 32'(O_Ready), 0);
        I_Wait = 1'b1;
        words.delete();
        for (int c = 0; c < 20; c++) begin
            if (O_Req_IF) words.push_back(O_Data_IF);
            tick();
        end
        checkOutput("t5_word_count", 32'(words.size()), 16);
        for (int i = 0; i < 16; i++)
            checkOutput("t5_word", (i < words.size()) ? words[i] : 32'hDEAD, 32'hE000_0000 + 32'(i));
        for (int i = 0; i < 3; i++) applyStimulus(32'hF0 + 32'(i), i == 2);
        words.delete();
        for (int c = 0; c < 8; c++) begin
            if (O_Req_IF) words.push_back(O_Data_IF);
            tick();
        end
        checkOutput("t5_wrap_count", 32'(words.size()), 3);
        for (int i = 0; i < 3; i++)
            checkOutput("t5_wrap_word", (i < words.size()) ? words[i] : 32'hDEAD, 32'hF0 + 32'(i));

        // Reset lands after two of five words have gone out.
        $display("[TB] reset mid-send");
        for (int i = 0; i < 5; i++) applyStimulus(32'h60 + 32'(i), i == 4);
        tick();
        checkOutput("t6_data0", O_Data_IF, 32'h60);
        tick();
        checkOutput("t6_data1", O_Data_IF, 32'h61);
        tick();
        checkOutput("t6_data2", O_Data_IF, 32'h62);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6_req",   32'(O_Req_IF), 0);
        checkOutput("t6_count", 32'(O_Count), 0);
        checkOutput("t6_data",  O_Data_IF, 0);
        checkOutput("t6_ready", 32'(O_Ready), 1);
        checkOutput("t6_state", 32'(dut.r_state), 32'(IDLE));
        reqSeen = 1'b0;
        doneSeen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            reqSeen  |= O_Req_IF;
            doneSeen |= O_Done;
            tick();
        end
        checkOutput("t6_no_req",  32'(reqSeen), 0);
        checkOutput("t6_no_done", 32'(doneSeen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
